imem_boot_loader: RTL and testbench

Serial program loader sitting directly upstream of the MIPS32 single-cycle core. It accepts a length-prefixed, checksummed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words into the core's instruction-memory write port and holds the core in reset until a complete, verified image has been written.

---
 rtl/imem_boot_loader.sv | 197 +++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Serial program loader for the MIPS32 single-cycle core. It consumes a
// length-prefixed, checksummed byte stream over a valid/ready handshake,
// assembles big-endian 32-bit instruction words and writes them through the
// core's instruction-memory write port. The core is held in reset until a
// complete image has been written and its checksum verified.
//
// Stream: LEN_HI, LEN_LO (word count N), 4*N payload bytes (MSB first per
//         word), CSUM = XOR of every preceding byte.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   in_data     stream byte
//   in_valid    in_data valid
//   in_ready    loader can accept a byte (registered-state decode)
//   imem_we     one-cycle instruction-memory write strobe (registered)
//   imem_addr   word address of the write (registered, holds afterwards)
//   imem_wdata  instruction word (registered, holds afterwards)
//   cpu_reset   active-high core reset; low only once the image is verified
//   done        image loaded and verified
//   err         load failed (checksum mismatch or address overflow)
//
// ADDR_WIDTH must lie in 1..16 because the word index is 16 bits wide.
// -----------------------------------------------------------------------------
module imem_boot_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  err
);

   // Number of words the attached instruction memory holds. Kept one bit
   // wider than the word index so ADDR_WIDTH=16 still compares correctly.
   localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CSUM,
      S_RUN,
      S_FAIL
   } state_t;

   state_t                  state_reg,    state_next;
   logic [15:0]             len_reg,      len_next;
   logic [15:0]             word_idx_reg, word_idx_next;
   logic [1:0]              byte_cnt_reg, byte_cnt_next;
   logic [7:0]              xor_reg,      xor_next;
   logic                    ovf_reg,      ovf_next;
   logic [23:0]             word_reg,     word_next;
   logic                    we_reg,       we_next;
   logic [ADDR_WIDTH-1:0]   addr_reg,     addr_next;
   logic [31:0]             wdata_reg,    wdata_next;

   logic ready_int;
   logic accept;
   logic idx_in_range;
   logic last_word;

   // Ready is a pure decode of the registered state, so it is high in the
   // very first cycle after reset release and drops together with done/err.
   assign ready_int = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) ||
                      (state_reg == S_DATA)   || (state_reg == S_CSUM);
   assign accept    = in_valid && ready_int;

   // Words past the end of memory are swallowed rather than aliased onto
   // low addresses; the sticky overflow flag then forces S_FAIL at CSUM.
   assign idx_in_range = ({1'b0, word_idx_reg} < DEPTH);
   assign last_word    = (word_idx_reg == (len_reg - 16'd1));

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= S_LEN_HI;
         len_reg      <= '0;
         word_idx_reg <= '0;
         byte_cnt_reg <= '0;
         xor_reg      <= '0;
         ovf_reg      <= 1'b0;
         word_reg     <= '0;
         we_reg       <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         len_reg      <= len_next;
         word_idx_reg <= word_idx_next;
         byte_cnt_reg <= byte_cnt_next;
         xor_reg      <= xor_next;
         ovf_reg      <= ovf_next;
         word_reg     <= word_next;
         we_reg       <= we_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      len_next      = len_reg;
      word_idx_next = word_idx_reg;
      byte_cnt_next = byte_cnt_reg;
      xor_next      = xor_reg;
      ovf_next      = ovf_reg;
      word_next     = word_reg;
      we_next       = 1'b0;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;

      done      = (state_reg == S_RUN);
      err       = (state_reg == S_FAIL);
      cpu_reset = (state_reg != S_RUN);

      case (state_reg)
         S_LEN_HI: begin
            if (accept) begin
               len_next   = {in_data, 8'h00};
               xor_next   = xor_reg ^ in_data;
               state_next = S_LEN_LO;
            end
         end

         S_LEN_LO: begin
            if (accept) begin
               len_next = {len_reg[15:8], in_data};
               xor_next = xor_reg ^ in_data;
               // An empty image goes straight to the checksum byte.
               if ((len_reg[15:8] == 8'h00) && (in_data == 8'h00)) begin
                  state_next = S_CSUM;
               end else begin
                  state_next = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (accept) begin
               xor_next      = xor_reg ^ in_data;
               word_next     = {word_reg[15:0], in_data};
               byte_cnt_next = byte_cnt_reg + 2'd1;
               if (byte_cnt_reg == 2'd3) begin
                  word_idx_next = word_idx_reg + 16'd1;
                  if (idx_in_range) begin
                     we_next    = 1'b1;
                     addr_next  = word_idx_reg[ADDR_WIDTH-1:0];
                     wdata_next = {word_reg, in_data};
                  end else begin
                     ovf_next = 1'b1;
                  end
                  if (last_word) begin
                     state_next = S_CSUM;
                  end
               end
            end
         end

         S_CSUM: begin
            if (accept) begin
               if ((xor_reg == in_data) && !ovf_reg) begin
                  state_next = S_RUN;
               end else begin
                  state_next = S_FAIL;
               end
            end
         end

         // Terminal states: only reset leaves them.
         S_RUN:   state_next = S_RUN;
         S_FAIL:  state_next = S_FAIL;
         default: state_next = S_FAIL;
      endcase
   end

   assign in_ready   = ready_int;
   assign imem_we    = we_reg;
   assign imem_addr  = addr_reg;
   assign imem_wdata = wdata_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Two loaders (ADDR_WIDTH=8 and ADDR_WIDTH=2) receive the same stream. A
// reference model derives the expected write list and verdict for each depth
// directly from the stream format; a negedge monitor records real writes.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;

    logic        rdy8, we8, cr8, dn8, er8;
    logic [7:0]  addr8;
    logic [31:0] wd8;
    logic        rdy2, we2, cr2, dn2, er2;
    logic [1:0]  addr2;
    logic [31:0] wd2;

    int errors = 0;
    int checks = 0;

    logic [7:0]  stim[$];
    logic [47:0] got8[$], got2[$], exp8[$], exp2[$];
    logic        ok8, ok2;

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy8), .imem_we(we8), .imem_addr(addr8), .imem_wdata(wd8),
        .cpu_reset(cr8), .done(dn8), .err(er8)
    );

    imem_boot_loader #(.ADDR_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy2), .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2),
        .cpu_reset(cr2), .done(dn2), .err(er2)
    );

    // Write monitor: every cycle with the strobe high is one write.
    always @(negedge clk) begin
        if (we8) got8.push_back({16'(addr8), wd8});
        if (we2) got2.push_back({16'(addr2), wd2});
    end

    // Reference model: parse the stream as the format defines it.
    task automatic compute_expect();
        int n;
        logic [7:0]  x;
        logic [31:0] w;
        exp8.delete();
        exp2.delete();
        n = int'({stim[0], stim[1]});
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * n; i++) x = x ^ stim[i];
        for (int i = 0; i < n; i++) begin
            w = {stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]};
            if (i < 256) exp8.push_back({16'(i), w});
            if (i < 4)   exp2.push_back({16'(i), w});
        end
        ok8 = (x == stim[2+4*n]) && (n <= 256);
        ok2 = (x == stim[2+4*n]) && (n <= 4);
    endtask

    task automatic make_stream(input int n, input bit good);
        logic [7:0] x;
        logic [7:0] b;
        stim.delete();
        stim.push_back(8'(n >> 8));
        stim.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
        x = 8'h00;
        foreach (stim[i]) x = x ^ stim[i];
        b = good ? x : (x ^ 8'($urandom_range(255, 1)));
        stim.push_back(b);
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        got8.delete();
        got2.delete();
    endtask

    // Drive the first cnt bytes of stim, with gap_min..gap_max idle cycles
    // before each byte, checking the write strobe after every accepting edge.
    task automatic send_stream(input int cnt, input int gap_min, input int gap_max);
        int n, idx, gaps;
        bit word_end;
        n = int'({stim[0], stim[1]});
        for (int k = 0; k < cnt; k++) begin
            gaps = $urandom_range(gap_max, gap_min);
            repeat (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk);
                #1;
            end
            checks++;
            if (rdy8 !== 1'b1 || rdy2 !== 1'b1) begin
                errors++;
                $display("FAIL ready byte %0d: in_ready8=%b in_ready2=%b want 1", k, rdy8, rdy2);
            end
            if (k == stim.size() - 1) begin
                checks++;
                if (cr8 !== 1'b1 || cr2 !== 1'b1 || dn8 !== 1'b0 || dn2 !== 1'b0) begin
                    errors++;
                    $display("FAIL pre_csum: cpu_reset8=%b cpu_reset2=%b done8=%b done2=%b want 1 1 0 0",
                             cr8, cr2, dn8, dn2);
                end
            end
            in_data  = stim[k];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            word_end = (k >= 5) && (k <= 1 + 4 * n) && (((k - 2) % 4) == 3);
            idx = (k - 2) / 4;
            checks++;
            if (we8 !== (word_end && idx < 256)) begin
                errors++;
                $display("FAIL we8 byte %0d: imem_we=%b want %b", k, we8, word_end && idx < 256);
            end
            checks++;
            if (we2 !== (word_end && idx < 4)) begin
                errors++;
                $display("FAIL we2 byte %0d: imem_we=%b want %b", k, we2, word_end && idx < 4);
            end
        end
    endtask

    task automatic check_final(input string name);
        int bad;
        int s8, s2;
        checks++;
        if (dn8 !== ok8 || er8 !== !ok8 || cr8 !== !ok8 || rdy8 !== 1'b0) begin
            errors++;
            $display("FAIL %s status8: done=%b err=%b cpu_reset=%b in_ready=%b want %b %b %b 0",
                     name, dn8, er8, cr8, rdy8, ok8, !ok8, !ok8);
        end
        checks++;
        if (dn2 !== ok2 || er2 !== !ok2 || cr2 !== !ok2 || rdy2 !== 1'b0) begin
            errors++;
            $display("FAIL %s status2: done=%b err=%b cpu_reset=%b in_ready=%b want %b %b %b 0",
                     name, dn2, er2, cr2, rdy2, ok2, !ok2, !ok2);
        end
        bad = 0;
        if (got8.size() != exp8.size()) bad = 1;
        else foreach (got8[i]) if (got8[i] !== exp8[i]) bad = 1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s writes8: got %0d writes (first %h) want %0d (first %h)", name,
                     got8.size(), (got8.size() > 0) ? got8[0] : 48'h0,
                     exp8.size(), (exp8.size() > 0) ? exp8[0] : 48'h0);
        end
        bad = 0;
        if (got2.size() != exp2.size()) bad = 1;
        else foreach (got2[i]) if (got2[i] !== exp2[i]) bad = 1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s writes2: got %0d writes want %0d", name, got2.size(), exp2.size());
        end
        // Extra bytes after a terminal state must be ignored.
        s8 = got8.size();
        s2 = got2.size();
        repeat (3) begin
            in_data  = 8'($urandom);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (got8.size() != s8 || got2.size() != s2 || dn8 !== ok8 || dn2 !== ok2 ||
            er8 !== !ok8 || er2 !== !ok2) begin
            errors++;
            $display("FAIL %s terminal: writes %0d/%0d done=%b/%b err=%b/%b want %0d/%0d %b/%b %b/%b",
                     name, got8.size(), got2.size(), dn8, dn2, er8, er2, s8, s2, ok8, ok2, !ok8, !ok2);
        end
        $display("txn %s: N=%0d writes8=%0d writes2=%0d done8=%b err2=%b",
                 name, int'({stim[0], stim[1]}), got8.size(), got2.size(), dn8, er2);
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (rdy8 !== 1'b1 || we8 !== 1'b0 || addr8 !== 8'h00 || wd8 !== 32'h0 ||
            cr8 !== 1'b1 || dn8 !== 1'b0 || er8 !== 1'b0) begin
            errors++;
            $display("FAIL %s rst8: rdy=%b we=%b addr=%h wdata=%h cpu_reset=%b done=%b err=%b want 1 0 00 00000000 1 0 0",
                     name, rdy8, we8, addr8, wd8, cr8, dn8, er8);
        end
        checks++;
        if (rdy2 !== 1'b1 || we2 !== 1'b0 || addr2 !== 2'b00 || wd2 !== 32'h0 ||
            cr2 !== 1'b1 || dn2 !== 1'b0 || er2 !== 1'b0) begin
            errors++;
            $display("FAIL %s rst2: rdy=%b we=%b addr=%h wdata=%h cpu_reset=%b done=%b err=%b want 1 0 0 00000000 1 0 0",
                     name, rdy2, we2, addr2, wd2, cr2, dn2, er2);
        end
    endtask

    task automatic load_nominal();
        stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;       // asserted before any clock edge
        #1;
        check_reset_values("reset_async");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("reset_release");
        $display("txn reset: in_ready=%b cpu_reset=%b", rdy8, cr8);
    endtask

    task automatic test_nominal();
        apply_reset();
        load_nominal();
        compute_expect();
        send_stream(stim.size(), 0, 0);
        checks++;
        if (got8.size() != 2 || got8[0] !== {16'h0000, 32'h20080005} ||
            got8[1] !== {16'h0001, 32'h2009000A}) begin
            errors++;
            $display("FAIL nominal_words: got %0d writes, first=%h want 2 writes 000020080005 00012009000a",
                     got8.size(), (got8.size() > 0) ? got8[0] : 48'h0);
        end
        checks++;
        if (dn8 !== 1'b1 || cr8 !== 1'b0) begin
            errors++;
            $display("FAIL nominal_done: done=%b cpu_reset=%b want 1 0", dn8, cr8);
        end
        check_final("nominal");
    endtask

    task automatic test_empty();
        apply_reset();
        stim = '{8'h00, 8'h00, 8'h00};
        compute_expect();
        send_stream(stim.size(), 0, 0);
        check_final("empty");
    endtask

    task automatic test_bad_csum();
        apply_reset();
        load_nominal();
        stim[10] = 8'h0D;
        compute_expect();
        send_stream(stim.size(), 0, 0);
        checks++;
        if (er8 !== 1'b1 || dn8 !== 1'b0 || cr8 !== 1'b1 || got8.size() != 2) begin
            errors++;
            $display("FAIL bad_csum: err=%b done=%b cpu_reset=%b writes=%0d want 1 0 1 2",
                     er8, dn8, cr8, got8.size());
        end
        check_final("bad_csum");
    endtask

    task automatic test_gaps();
        apply_reset();
        load_nominal();
        compute_expect();
        send_stream(stim.size(), 1, 3);
        check_final("gaps");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        load_nominal();
        compute_expect();
        send_stream(6, 0, 0);
        #2 reset = 1'b0;       // lands while the word-0 strobe is high
        #1;
        check_reset_values("reset_mid");
        @(negedge clk);
        reset = 1'b1;
        got8.delete();
        got2.delete();
        send_stream(stim.size(), 0, 0);
        check_final("reset_mid_reload");
    endtask

    task automatic test_overflow();
        apply_reset();
        make_stream(5, 1'b1);
        compute_expect();
        send_stream(stim.size(), 0, 0);
        checks++;
        if (got2.size() != 4 || er2 !== 1'b1 || cr2 !== 1'b1 || dn8 !== 1'b1) begin
            errors++;
            $display("FAIL overflow: writes2=%0d err2=%b cpu_reset2=%b done8=%b want 4 1 1 1",
                     got2.size(), er2, cr2, dn8);
        end
        check_final("overflow");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            apply_reset();
            make_stream($urandom_range(6, 0), $urandom_range(3, 0) != 0);
            compute_expect();
            send_stream(stim.size(), 0, 2);
            check_final($sformatf("random%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_empty();
        test_bad_csum();
        test_gaps();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
